conv_pass_seq: RTL and testbench

CONV_PASS_SEQ -- requirements
Module: conv_pass_seq

---
 rtl/conv_pass_seq.sv | 128 ++++++++++++
 tb/tb_conv_pass_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conv_pass_seq.sv
// Sequencer for one convolution layer: launches NUM_KIJ core passes, swaps the
// ping-pong chip select between passes, then dumps LEN_NIJ output pixels.
module conv_pass_seq #(
   parameter int KSIZE   = 3,
   parameter int LEN_NIJ = 16,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       core_done,
   output logic       start_kij,
   output logic [3:0] kij,
   output logic [3:0] inst_tb,
   output logic       busy,
   output logic       layer_done,
   output logic       error
);

   localparam int NUM_KIJ = KSIZE * KSIZE;
   localparam int WW      = $clog2(TIMEOUT + 2);
   localparam int DW      = $clog2(LEN_NIJ + 1);

   localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
   localparam logic [DW-1:0] DUMP_LAST = DW'(LEN_NIJ - 1);
   localparam logic [3:0]    KIJ_LAST  = 4'(NUM_KIJ - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SWAP   = 3'd3;
   localparam logic [2:0] S_DUMP   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   logic [2:0]    state, state_n;
   logic [3:0]    kij_n;
   logic          rchip, rchip_n;
   logic          first_pass, first_n;
   logic          mem_write, final_rd;
   logic [WW-1:0] wait_cnt, wait_n;
   logic [DW-1:0] dump_cnt, dump_n;

   always_comb begin
      state_n = state;
      kij_n   = kij;
      rchip_n = rchip;
      first_n = first_pass;
      wait_n  = wait_cnt;
      dump_n  = dump_cnt;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_n = S_LAUNCH;
               kij_n   = '0;
               rchip_n = 1'b0;
               first_n = 1'b1;
               wait_n  = '0;
               dump_n  = '0;
            end
         end
         S_LAUNCH: begin
            state_n = S_WAIT;
            wait_n  = '0;
         end
         S_WAIT: begin
            // rchip/first_pass change on SWAP entry so their registered value is visible during SWAP
            if (core_done) begin
               state_n = S_SWAP;
               rchip_n = ~rchip;
               first_n = 1'b0;
            end else if (wait_cnt == WAIT_MAX) begin
               state_n = S_ERR;
            end else begin
               wait_n = wait_cnt + 1'b1;
            end
         end
         S_SWAP: begin
            if (kij == KIJ_LAST) begin
               state_n = S_DUMP;
               dump_n  = '0;
            end else begin
               state_n = S_LAUNCH;
               kij_n   = kij + 4'd1;
            end
         end
         S_DUMP: begin
            if (dump_cnt == DUMP_LAST) state_n = S_DONE;
            else dump_n = dump_cnt + 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         kij        <= '0;
         rchip      <= 1'b0;
         first_pass <= 1'b0;
         wait_cnt   <= '0;
         dump_cnt   <= '0;
         start_kij  <= 1'b0;
         mem_write  <= 1'b0;
         final_rd   <= 1'b0;
         busy       <= 1'b0;
         layer_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         kij        <= kij_n;
         rchip      <= rchip_n;
         first_pass <= first_n;
         wait_cnt   <= wait_n;
         dump_cnt   <= dump_n;
         start_kij  <= (state_n == S_LAUNCH);
         mem_write  <= (state_n == S_LAUNCH) || (state_n == S_WAIT);
         final_rd   <= (state_n == S_DUMP);
         busy       <= !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_ERR));
         layer_done <= (state_n == S_DONE);
         error      <= (state_n == S_ERR);
      end
   end

   assign inst_tb = {final_rd, rchip, mem_write, first_pass};

endmodule

// File: tb/tb_conv_pass_seq.sv
// Directed self-checking bench for conv_pass_seq with default parameters.
module tb_conv_pass_seq;

   localparam int TIMEOUT = 255;

   logic       clk = 1'b0;
   logic       reset, start, core_done;
   logic       start_kij, busy, layer_done, error;
   logic [3:0] kij, inst_tb;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned pulses = 0;
   int unsigned p0;

   conv_pass_seq #(.KSIZE(3), .LEN_NIJ(16), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .core_done  (core_done),
      .start_kij  (start_kij),
      .kij        (kij),
      .inst_tb    (inst_tb),
      .busy       (busy),
      .layer_done (layer_done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (start_kij === 1'b1) pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_kij"}, kij, 0);
      chk({tag, "_inst"}, inst_tb, 0);
      chk({tag, "_skij"}, start_kij, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, layer_done, 0);
      chk({tag, "_err"}, error, 0);
   endtask

   // Full layer: core_done answers 5 cycles after each start_kij
   task automatic run_layer(input bit spur);
      logic [3:0] e;
      int unsigned pbase;
      pbase = pulses;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         e = {1'b0, (k % 2) == 1, 1'b1, k == 0};
         chk("launch_skij", start_kij, 1);
         chk("launch_kij", kij, k);
         chk("launch_inst", inst_tb, e);
         chk("launch_err", error, 0);
         tick();
         chk("wait_skij", start_kij, 0);
         chk("wait_inst", inst_tb, e);
         for (int w = 0; w < 4; w++) begin
            if (spur && k == 2 && w == 1) start = 1'b1;
            tick();
            start = 1'b0;
         end
         chk("wait_hold_kij", kij, k);
         chk("wait_hold_skij", start_kij, 0);
         chk("wait_hold_inst", inst_tb, e);
         core_done = 1'b1;
         tick();
         core_done = 1'b0;
         e = {1'b0, ((k + 1) % 2) == 1, 1'b0, 1'b0};
         chk("swap_inst", inst_tb, e);
         chk("swap_busy", busy, 1);
         tick();
      end
      chk("dump_kij", kij, 8);
      for (int i = 0; i < 16; i++) begin
         chk("dump_inst", inst_tb, 4'b1100);
         chk("dump_done", layer_done, 0);
         if (spur && i == 3) core_done = 1'b1;
         if (i == 6) core_done = 1'b0;
         tick();
      end
      chk("done_flag", layer_done, 1);
      chk("done_busy", busy, 0);
      chk("done_inst", inst_tb, 4'b0100);
      chk("done_kij", kij, 8);
      chk("layer_pulses", pulses - pbase, 9);
      tick();
      chk("done_hold", layer_done, 1);
   endtask

   initial begin
      // reset takes precedence over simultaneous start/core_done
      reset = 1'b1;
      start = 1'b1;
      core_done = 1'b1;
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      start = 1'b0;
      core_done = 1'b0;
      tick();
      chk_all_zero("idle");

      run_layer(1'b0);

      // timeout from DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (TIMEOUT) tick();
      chk("to_before_err", error, 0);
      chk("to_before_busy", busy, 1);
      tick();
      chk("to_err", error, 1);
      chk("to_kij", kij, 0);
      chk("to_busy", busy, 0);
      chk("to_skij", start_kij, 0);
      tick();
      chk("to_err_hold", error, 1);

      // restart from ERR, with spurious start in WAIT and core_done in DUMP
      run_layer(1'b1);

      // abort mid-layer at kij=4
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         core_done = 1'b1;
         tick();
         core_done = 1'b0;
         tick();
      end
      tick();
      chk("mid_kij", kij, 4);
      chk("mid_inst", inst_tb, 4'b0010);
      reset = 1'b1;
      p0 = pulses;
      tick();
      reset = 1'b0;
      chk_all_zero("mid_reset");
      tick();
      tick();
      chk("mid_no_pulse", pulses - p0, 0);
      chk_all_zero("mid_idle");

      // core_done during LAUNCH is not latched
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fresh_kij", kij, 0);
      chk("fresh_inst", inst_tb, 4'b0011);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("nolatch_wait", inst_tb, 4'b0011);
      tick();
      chk("nolatch_wait2", inst_tb, 4'b0011);
      chk("nolatch_busy", busy, 1);

      // core_done on first WAIT cycle goes straight to SWAP
      reset = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      chk("fast_swap_inst", inst_tb, 4'b0100);
      tick();
      chk("fast_launch_skij", start_kij, 1);
      chk("fast_launch_kij", kij, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
